// File: rtl/aes_wb_burst.sv
// aes_wb_burst: stores a DATA_W-bit AES result to memory as a burst of
// BUS_W-bit word writes over a req/gnt bus, halting the core meanwhile.
module aes_wb_burst #(
   parameter int DATA_W = 128,
   parameter int BUS_W  = 32,
   parameter int ADDR_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [ADDR_W-1:0]    addr_i,
   input  logic [DATA_W-1:0]    data_i,
   input  logic                 swap_i,
   input  logic                 gnt_i,
   output logic                 req_o,
   output logic                 we_o,
   output logic [ADDR_W-1:0]    addr_o,
   output logic [BUS_W-1:0]     wdata_o,
   output logic [BUS_W/8-1:0]   be_o,
   output logic                 halt_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o
);

   localparam int NBEATS = DATA_W / BUS_W;
   localparam int STRIDE = BUS_W / 8;
   localparam int AL     = $clog2(STRIDE);
   localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr_q;     // address of the beat currently presented
   logic [DATA_W-1:0] data_q;     // remaining beats, current beat in low bits
   logic              swap_q;
   logic [CW-1:0]     cnt;
   logic              err_q;
   logic              misalign, accept, last;
   logic [BUS_W-1:0]  word, word_rev;

   assign misalign = |addr_i[AL-1:0];
   assign accept   = (state == IDLE) && start_i && !misalign;
   assign last     = (cnt == CW'(NBEATS - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state and control outputs
   always_comb begin
      state_nx = state;
      req_o    = 1'b0;
      busy_o   = 1'b0;
      done_o   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nx = WRITE;
         end
         WRITE: begin
            req_o  = 1'b1;
            busy_o = 1'b1;
            if (gnt_i && last) state_nx = FINISH;
         end
         FINISH: begin
            busy_o   = 1'b1;
            done_o   = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Operand latch at start; advance address and beat on each grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         data_q <= '0;
         swap_q <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         addr_q <= addr_i;
         data_q <= data_i;
         swap_q <= swap_i;
         cnt    <= '0;
      end else if (state == WRITE && gnt_i) begin
         addr_q <= addr_q + ADDR_W'(STRIDE);
         data_q <= data_q >> BUS_W;
         cnt    <= cnt + CW'(1);
      end
   end

   // Misaligned start reported as a one-cycle pulse, only from IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= (state == IDLE) && start_i && misalign;
   end

   assign word = data_q[BUS_W-1:0];

   for (genvar b = 0; b < STRIDE; b++) begin : g_rev
      assign word_rev[b*8 +: 8] = word[(STRIDE-1-b)*8 +: 8];
   end

   // Bus fields are zero whenever no request is pending
   assign we_o    = req_o;
   assign halt_o  = busy_o;
   assign err_o   = err_q;
   assign be_o    = req_o ? '1 : '0;
   assign addr_o  = req_o ? addr_q : '0;
   assign wdata_o = req_o ? (swap_q ? word_rev : word) : '0;

endmodule

// File: tb/tb_aes_wb_burst.sv
// Bench for aes_wb_burst: a 128/32 instance and a 256/64 instance, driven by
// directed and random bursts and checked against a beat-list reference model.
module tb_aes_wb_burst;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // instance 0: DATA_W=128, BUS_W=32
   logic         s0 = 0, sw0 = 0, g0 = 0;
   logic [31:0]  a0 = 0;
   logic [127:0] d0 = 0;
   logic         r0, we0, h0, bz0, dn0, e0;
   logic [31:0]  ao0, wd0;
   logic [3:0]   be0;

   // instance 1: DATA_W=256, BUS_W=64
   logic         s1 = 0, sw1 = 0, g1 = 0;
   logic [31:0]  a1 = 0;
   logic [255:0] d1 = 0;
   logic         r1, we1, h1, bz1, dn1, e1;
   logic [31:0]  ao1;
   logic [63:0]  wd1;
   logic [7:0]   be1;

   aes_wb_burst #(.DATA_W(128), .BUS_W(32), .ADDR_W(32)) u0 (
      .clk(clk), .rst_n(rst_n), .start_i(s0), .addr_i(a0), .data_i(d0),
      .swap_i(sw0), .gnt_i(g0), .req_o(r0), .we_o(we0), .addr_o(ao0),
      .wdata_o(wd0), .be_o(be0), .halt_o(h0), .busy_o(bz0), .done_o(dn0),
      .err_o(e0));

   aes_wb_burst #(.DATA_W(256), .BUS_W(64), .ADDR_W(32)) u1 (
      .clk(clk), .rst_n(rst_n), .start_i(s1), .addr_i(a1), .data_i(d1),
      .swap_i(sw1), .gnt_i(g1), .req_o(r1), .we_o(we1), .addr_o(ao1),
      .wdata_o(wd1), .be_o(be1), .halt_o(h1), .busy_o(bz1), .done_o(dn1),
      .err_o(e1));

   int checks = 0;
   int failures = 0;

   logic        o_req, o_we, o_halt, o_busy, o_done, o_err;
   logic [31:0] o_addr;
   logic [63:0] o_wd;
   logic [7:0]  o_be;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sample(input int w);
      if (w == 0) begin
         o_req = r0; o_we = we0; o_halt = h0; o_busy = bz0; o_done = dn0; o_err = e0;
         o_addr = ao0; o_wd = {32'b0, wd0}; o_be = {4'b0, be0};
      end else begin
         o_req = r1; o_we = we1; o_halt = h1; o_busy = bz1; o_done = dn1; o_err = e1;
         o_addr = ao1; o_wd = wd1; o_be = be1;
      end
   endtask

   task automatic drive(input int w, input logic st, input logic [31:0] a,
                        input logic [255:0] d, input logic sw);
      if (w == 0) begin s0 = st; a0 = a; d0 = d[127:0]; sw0 = sw; end
      else        begin s1 = st; a1 = a; d1 = d;        sw1 = sw; end
   endtask

   task automatic set_gnt(input int w, input logic g);
      if (w == 0) g0 = g; else g1 = g;
   endtask

   // Reference: beat k is the k-th bw-bit slice, optionally byte-reversed
   function automatic logic [63:0] model_word(input logic [255:0] d, input int k,
                                              input int bw, input logic sw);
      logic [255:0] sh;
      logic [63:0]  w, r;
      sh = d >> (k * bw);
      w  = sh[63:0];
      if (bw == 32) w[63:32] = 32'b0;
      if (!sw) return w;
      r = '0;
      for (int i = 0; i < bw / 8; i++) r[i*8 +: 8] = w[(bw/8-1-i)*8 +: 8];
      return r;
   endfunction

   task automatic check_idle(input int w, input string tag);
      sample(w);
      chk({tag, "_req"},  o_req,  1'b0);
      chk({tag, "_halt"}, o_halt, 1'b0);
      chk({tag, "_busy"}, o_busy, 1'b0);
      chk({tag, "_done"}, o_done, 1'b0);
   endtask

   // mode 0: always granted, 1: two stall cycles on beats 1 and 3, 2: random
   task automatic run_burst(input int w, input logic [31:0] a, input logic [255:0] d,
                            input logic sw, input int mode);
      int bw, nb, k, stalls, lat, held;
      logic g;
      logic [31:0] ea;
      bw = (w == 0) ? 32 : 64;
      nb = ((w == 0) ? 128 : 256) / bw;
      k = 0; stalls = 0; held = 0;
      drive(w, 1'b1, a, d, sw);
      set_gnt(w, 1'b0);
      @(negedge clk);
      // scramble inputs after latch; the burst must not see them
      drive(w, 1'b0, $urandom, {$urandom, $urandom, $urandom, $urandom,
                                $urandom, $urandom, $urandom, $urandom}, ~sw);
      lat = 1;
      while (k < nb && lat < 60) begin
         sample(w);
         ea = a + 32'(k * (bw / 8));
         chk("beat_req",  o_req,  1'b1);
         chk("beat_we",   o_we,   1'b1);
         chk("beat_halt", o_halt, 1'b1);
         chk("beat_busy", o_busy, 1'b1);
         chk("beat_done", o_done, 1'b0);
         chk("beat_err",  o_err,  1'b0);
         chk("beat_addr", o_addr, ea);
         chk("beat_wdata", o_wd, model_word(d, k, bw, sw));
         chk("beat_be",   o_be, (w == 0) ? 8'h0F : 8'hFF);
         if (mode == 0)      g = 1'b1;
         else if (mode == 1) g = !((k == 1 || k == 3) && held < 2);
         else                g = ($urandom_range(0, 2) != 0);
         if (g) begin k++; held = 0; end
         else   begin stalls++; held++; end
         set_gnt(w, g);
         @(negedge clk);
         lat++;
      end
      chk("burst_bound", (lat < 60), 1'b1);
      // FINISH: start and stray grant must be ignored here
      drive(w, 1'b1, {$urandom_range(0, 255), 8'h00}, d, sw);
      set_gnt(w, 1'($urandom));
      sample(w);
      chk("fin_done", o_done, 1'b1);
      chk("fin_req",  o_req,  1'b0);
      chk("fin_halt", o_halt, 1'b1);
      chk("fin_err",  o_err,  1'b0);
      chk("fin_addr", o_addr, 32'h0);
      chk("latency",  lat, nb + stalls + 1);
      @(negedge clk);
      drive(w, 1'b0, 32'h0, '0, 1'b0);
      set_gnt(w, 1'b0);
      check_idle(w, "post");
   endtask

   task automatic misaligned(input int w, input logic [31:0] a);
      drive(w, 1'b1, a, '1, 1'b0);
      @(negedge clk);
      drive(w, 1'b0, 32'h0, '0, 1'b0);
      sample(w);
      chk("mis_err", o_err, 1'b1);
      check_idle(w, "mis");
      @(negedge clk);
      sample(w);
      chk("mis_err_clr", o_err, 1'b0);
      check_idle(w, "mis2");
   endtask

   logic [255:0] rd;
   logic [31:0]  ra;

   initial begin
      // reset values
      #1;
      for (int w = 0; w < 2; w++) begin
         sample(w);
         chk("rst_req", o_req, 1'b0); chk("rst_we", o_we, 1'b0);
         chk("rst_halt", o_halt, 1'b0); chk("rst_busy", o_busy, 1'b0);
         chk("rst_done", o_done, 1'b0); chk("rst_err", o_err, 1'b0);
         chk("rst_addr", o_addr, 32'h0); chk("rst_wdata", o_wd, 64'h0);
         chk("rst_be", o_be, 8'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // basic, then back-to-back stalled burst started right after done
      run_burst(0, 32'h1000, 256'h44444444_33333333_22222222_11111111, 1'b0, 0);
      run_burst(0, 32'h1000, 256'h44444444_33333333_22222222_11111111, 1'b0, 1);
      // swap
      run_burst(0, 32'h2000, 256'h01020304_05060708_090A0B0C_AABBCCDD, 1'b1, 0);
      chk("swap_const", model_word(256'hAABBCCDD, 0, 32, 1'b1), 64'hDDCCBBAA);
      // misaligned
      misaligned(0, 32'h1002);
      misaligned(1, 32'h1004);
      misaligned(1, 32'h1001);
      // wrap on the wide instance
      run_burst(1, 32'hFFFF_FFF0, {$urandom, $urandom, $urandom, $urandom,
                                   $urandom, $urandom, $urandom, $urandom}, 1'b0, 0);
      run_burst(1, 32'hFFFF_FFF0, {$urandom, $urandom, $urandom, $urandom,
                                   $urandom, $urandom, $urandom, $urandom}, 1'b1, 2);

      // reset mid-burst
      drive(0, 1'b1, 32'h3000, 256'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0, 1'b0);
      @(negedge clk);
      drive(0, 1'b0, 32'h0, '0, 1'b0);
      g0 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      sample(0);
      chk("mrst_req", o_req, 1'b0); chk("mrst_halt", o_halt, 1'b0);
      chk("mrst_busy", o_busy, 1'b0); chk("mrst_done", o_done, 1'b0);
      chk("mrst_addr", o_addr, 32'h0); chk("mrst_wdata", o_wd, 64'h0);
      chk("mrst_be", o_be, 8'h0);
      @(negedge clk);
      rst_n = 1'b1;
      g0 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_idle(0, "after_rst");
      end
      run_burst(0, 32'h3000, 256'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0, 1'b0, 0);

      // random bursts on both instances
      for (int i = 0; i < 12; i++) begin
         rd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         ra = $urandom;
         ra[2:0] = 3'b000;
         if (i[0]) ra[2] = 1'($urandom);
         run_burst(i % 2, (i % 2 == 1) ? {ra[31:3], 3'b000} : ra, rd,
                   1'($urandom), 2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
